// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Brief    : SPI initiator; serializes 11-bit RAM command frames on ss_n/mosi
//            and captures the read-data byte returned on miso.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master #(
  parameter int DATA_W      = 8,
  parameter int TURN_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              ss_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int c_frame_w = DATA_W + 3;
  localparam int c_max_a   = (c_frame_w > TURN_CYCLES) ? c_frame_w : TURN_CYCLES;
  localparam int c_max     = (c_max_a > DATA_W) ? c_max_a : DATA_W;
  localparam int c_cnt_w   = $clog2(c_max + 1);

  // Counters hold "cycles remaining after this one"; GAP_CYCLES must fit c_cnt_w.
  localparam logic [c_cnt_w-1:0] c_send_load = c_cnt_w'(c_frame_w - 1);
  localparam logic [c_cnt_w-1:0] c_turn_load = (TURN_CYCLES > 0) ? c_cnt_w'(TURN_CYCLES - 1) : '0;
  localparam logic [c_cnt_w-1:0] c_recv_load = c_cnt_w'(DATA_W - 1);
  localparam logic [c_cnt_w-1:0] c_gap_load  = c_cnt_w'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_TURN = 3'd2,
    ST_RECV = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic [c_frame_w-2:0] frame_q, frame_d;
  logic                is_rd_q, is_rd_d;
  logic [DATA_W-2:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                ss_n_q, ss_n_d;
  logic                mosi_q, mosi_d;
  logic [DATA_W-1:0]   sample_word;

  // The frame's leading mode bit goes straight to mosi at accept, so frame_q
  // only keeps the bits still to be sent, MSB aligned.
  assign sample_word = {shift_q, miso};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_d     = frame_q;
    is_rd_d     = is_rd_q;
    shift_d     = shift_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    mosi_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_SEND;
          cnt_d   = c_send_load;
          frame_d = {cmd_op, cmd_data};
          is_rd_d = &cmd_op;
          mosi_d  = cmd_op[1];
        end
      end
      ST_SEND: begin
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - 1'b1;
          mosi_d  = frame_q[c_frame_w-2];
          frame_d = {frame_q[c_frame_w-3:0], 1'b0};
        end else if (!is_rd_q) begin
          state_d = ST_GAP;
          cnt_d   = c_gap_load;
        end else if (TURN_CYCLES > 0) begin
          state_d = ST_TURN;
          cnt_d   = c_turn_load;
        end else begin
          state_d = ST_RECV;
          cnt_d   = c_recv_load;
          shift_d = '0;
        end
      end
      ST_TURN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_RECV;
          cnt_d   = c_recv_load;
          shift_d = '0;
        end
      end
      ST_RECV: begin
        shift_d = sample_word[DATA_W-2:0];
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d     = ST_GAP;
          cnt_d       = c_gap_load;
          rsp_data_d  = sample_word;
          rsp_valid_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    ss_n_d = (state_d == ST_IDLE) || (state_d == ST_GAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      frame_q     <= '0;
      is_rd_q     <= 1'b0;
      shift_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      is_rd_q     <= is_rd_d;
      shift_q     <= shift_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign ss_n      = ss_n_q;
  assign mosi      = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master
// Brief    : Directed self-checking bench for spi_master with a behavioural
//            SPI slave + RAM model, plus a TURN_CYCLES=0 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       cmd_valid, cmd_ready, rsp_valid, busy, ss_n, mosi, miso;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data, rsp_data;

  logic       cmd_valid0, cmd_ready0, rsp_valid0, busy0, ss_n0, mosi0, miso0;
  logic [1:0] cmd_op0;
  logic [7:0] cmd_data0, rsp_data0;

  int n_checks = 0;
  int n_errors = 0;

  spi_master #(.DATA_W(8), .TURN_CYCLES(2), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .ss_n(ss_n), .mosi(mosi), .miso(miso)
  );

  spi_master #(.DATA_W(8), .TURN_CYCLES(0), .GAP_CYCLES(1)) dut_t0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_op(cmd_op0), .cmd_data(cmd_data0), .rsp_valid(rsp_valid0),
    .rsp_data(rsp_data0), .busy(busy0), .ss_n(ss_n0), .mosi(mosi0), .miso(miso0)
  );

  // Slave + RAM model: counts ss_n-low cycles, decodes the frame on its last
  // bit, and returns mem[addr] MSB first once the turnaround has elapsed.
  logic [7:0] mem [256];
  logic [7:0] sl_addr;
  logic [9:0] sl_sh;
  int         sl_cnt;
  logic       ovr_en;
  logic [7:0] ovr_byte, rd_byte;
  int         rd_idx;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hC3;
      sl_addr <= 8'h00;
    end
    if (ss_n) begin
      sl_cnt <= 0;
      sl_sh  <= '0;
    end else begin
      sl_cnt <= sl_cnt + 1;
      if (sl_cnt < 10) sl_sh <= {sl_sh[8:0], mosi};
      else if (sl_cnt == 10) begin
        case (sl_sh[8:7])
          2'b00:   sl_addr <= {sl_sh[6:0], mosi};
          2'b01:   mem[sl_addr] <= {sl_sh[6:0], mosi};
          2'b10:   sl_addr <= {sl_sh[6:0], mosi};
          default: ;
        endcase
      end
    end
  end

  // Outside the read window miso carries junk the master must ignore.
  always_comb begin
    rd_byte = ovr_en ? ovr_byte : mem[sl_addr];
    rd_idx  = sl_cnt - 13;
    miso    = sl_cnt[0];
    if (!ss_n && rd_idx >= 0 && rd_idx < 8) miso = rd_byte[7 - rd_idx];
  end

  int         sl0_cnt;
  int         rd0_idx;
  logic [7:0] byte0;
  always @(posedge clk) begin
    if (ss_n0) sl0_cnt <= 0;
    else       sl0_cnt <= sl0_cnt + 1;
  end
  always_comb begin
    byte0   = 8'h81;
    rd0_idx = sl0_cnt - 11;
    miso0   = ~sl0_cnt[0];
    if (!ss_n0 && rd0_idx >= 0 && rd0_idx < 8) miso0 = byte0[7 - rd0_idx];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!cmd_ready && k < 60) begin
      tick();
      k++;
    end
    check("ready_timeout", {31'b0, cmd_ready}, 32'd1);
  endtask

  // Returns in cycle T+1 (the first cycle after the accepting edge).
  task automatic accept(input logic [1:0] op, input logic [7:0] data);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_data  = ~data;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] data,
                         output int pulses, output logic [7:0] last);
    int k = 0;
    accept(op, data);
    pulses = 0;
    last   = 8'h00;
    while (!cmd_ready && k < 40) begin
      if (rsp_valid) begin
        pulses++;
        last = rsp_data;
      end
      tick();
      k++;
    end
  endtask

  task automatic e2e(input logic [7:0] addr, input logic [7:0] data);
    int         p;
    logic [7:0] last;
    run_cmd(2'b00, addr, p, last);
    run_cmd(2'b01, data, p, last);
    run_cmd(2'b10, addr, p, last);
    run_cmd(2'b11, 8'h00, p, last);
    check("e2e_pulses", p, 32'd1);
    check("e2e_rsp_byte", {24'b0, last}, {24'b0, data});
    check("e2e_rsp_hold", {24'b0, rsp_data}, {24'b0, data});
  endtask

  initial begin
    logic [10:0] exp_bits;
    logic [1:0]  ops [3];
    logic [7:0]  dats [3];
    int          p, idx, hi_run, nfr;
    logic        prev_low, acc;
    logic [7:0]  last;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
    cmd_valid0 = 1'b0; cmd_op0 = 2'b00; cmd_data0 = 8'h00;
    ovr_en = 1'b0; ovr_byte = 8'h00;
    repeat (3) tick();
    check("rst_ss_n", {31'b0, ss_n}, 32'd1);
    check("rst_mosi", {31'b0, mosi}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'b0, rsp_data}, 32'd0);
    rst = 1'b0;
    tick();
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // wr-addr 0x3A: frame 0_00_00111010
    exp_bits = 11'b000_0011_1010;
    accept(2'b00, 8'h3A);
    for (int i = 0; i < 11; i++) begin
      check("t1_ss_n_low", {31'b0, ss_n}, 32'd0);
      check("t1_mosi", {31'b0, mosi}, {31'b0, exp_bits[10-i]});
      check("t1_ready_low", {31'b0, cmd_ready}, 32'd0);
      check("t1_no_rsp", {31'b0, rsp_valid}, 32'd0);
      tick();
    end
    check("t1_gap_ss_n", {31'b0, ss_n}, 32'd1);
    check("t1_gap_busy", {31'b0, busy}, 32'd1);
    check("t1_gap_no_rsp", {31'b0, rsp_valid}, 32'd0);
    tick();
    check("t1_idle_ready", {31'b0, cmd_ready}, 32'd1);
    check("t1_idle_busy", {31'b0, busy}, 32'd0);

    // rd-data with miso forced to 0xA5; response at T+22
    ovr_en = 1'b1; ovr_byte = 8'hA5;
    accept(2'b11, 8'h00);
    for (int k = 1; k <= 23; k++) begin
      if (k <= 3) check("t2_mosi_hdr", {31'b0, mosi}, 32'd1);
      if (k <= 21) check("t2_ss_n_low", {31'b0, ss_n}, 32'd0);
      check("t2_rsp_valid", {31'b0, rsp_valid}, {31'b0, k == 22});
      if (k == 22) begin
        check("t2_rsp_data", {24'b0, rsp_data}, 32'hA5);
        check("t2_gap_ss_n", {31'b0, ss_n}, 32'd1);
      end
      if (k == 23) check("t2_ready_back", {31'b0, cmd_ready}, 32'd1);
      if (k < 23) tick();
    end
    ovr_en = 1'b0;
    run_cmd(2'b01, 8'h77, p, last);
    check("t2_wr_no_rsp", p, 32'd0);
    check("t2_rsp_held", {24'b0, rsp_data}, 32'hA5);

    // back-to-back with cmd_valid held high
    ops[0] = 2'b00; dats[0] = 8'h20;
    ops[1] = 2'b01; dats[1] = 8'h99;
    ops[2] = 2'b10; dats[2] = 8'h20;
    wait_ready();
    idx = 0; hi_run = 0; nfr = 0; prev_low = 1'b0;
    cmd_valid = 1'b1; cmd_op = ops[0]; cmd_data = dats[0];
    for (int c = 0; c < 60; c++) begin
      acc = cmd_valid && cmd_ready;
      if (!ss_n) begin
        if (!prev_low) begin
          nfr++;
          if (nfr > 1) check("t3_gap_len", hi_run, 32'd2);
        end
        check("t3_ready_low", {31'b0, cmd_ready}, 32'd0);
        hi_run = 0;
        prev_low = 1'b1;
      end else begin
        hi_run++;
        prev_low = 1'b0;
      end
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) begin
          cmd_op = ops[idx]; cmd_data = dats[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    check("t3_frames", nfr, 32'd3);
    run_cmd(2'b11, 8'h00, p, last);
    check("t3_rd_pulses", p, 32'd1);
    check("t3_rd_byte", {24'b0, last}, 32'h99);

    // reset during cycle T+6 of a wr-data frame
    accept(2'b01, 8'h55);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("t4_ss_n", {31'b0, ss_n}, 32'd1);
    check("t4_mosi", {31'b0, mosi}, 32'd0);
    check("t4_busy", {31'b0, busy}, 32'd0);
    check("t4_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("t4_rsp_data", {24'b0, rsp_data}, 32'd0);
    rst = 1'b0;
    tick();
    check("t4_ready", {31'b0, cmd_ready}, 32'd1);

    e2e(8'h10, 8'h5C);
    e2e(8'hFF, 8'h00);

    // TURN_CYCLES=0 instance: response at T+20
    idx = 0;
    while (!cmd_ready0 && idx < 60) begin
      tick();
      idx++;
    end
    check("t6_ready", {31'b0, cmd_ready0}, 32'd1);
    cmd_valid0 = 1'b1; cmd_op0 = 2'b11; cmd_data0 = 8'h00;
    tick();
    cmd_valid0 = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      check("t6_rsp_valid", {31'b0, rsp_valid0}, {31'b0, k == 20});
      if (k == 20) check("t6_rsp_data", {24'b0, rsp_data0}, 32'h81);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
